serial_cmp_ge: RTL



---
 rtl/serial_cmp_ge.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_cmp_ge.sv
// Digit-serial MSB-first unsigned comparator: reports A >= B and A == B,
// examining one digit per cycle and stopping at the first differing digit.
module serial_cmp_ge #(
    parameter int width = 8,
    parameter int digit = 2,
    parameter int speed = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             InValid,
    output logic             InReady,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             GE,
    output logic             EQ
);

    localparam int D    = (width + digit - 1) / digit;
    localparam int PW   = D * digit;
    localparam int IW   = (D > 1) ? $clog2(D) : 1;
    localparam int FAST = 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    a_r;
    logic [PW-1:0]    b_r;
    logic [digit-1:0] ad;
    logic [digit-1:0] bd;
    logic             ge_d;
    logic             eq_d;

    function automatic logic [digit-1:0] pick(input logic [PW-1:0] v, input logic [IW-1:0] i);
        return digit'(v >> (int'(i) * digit));
    endfunction

    // The small variant resolves the digit LSB-first as a ripple chain.
    function automatic logic digit_ge(input logic [digit-1:0] x, input logic [digit-1:0] y);
        logic g;
        if (speed == FAST) begin
            g = (x >= y);
        end else begin
            g = 1'b1;
            for (int k = 0; k < digit; k++)
                g = (x[k] & ~y[k]) | (~(x[k] ^ y[k]) & g);
        end
        return g;
    endfunction

    assign ad       = pick(a_r, idx);
    assign bd       = pick(b_r, idx);
    assign ge_d     = digit_ge(ad, bd);
    assign eq_d     = (ad == bd);
    assign InReady  = (state == IDLE);
    assign OutValid = (state == DONE);

    // Operands are data only: captured on accept, never reset.
    always_ff @(posedge CLK) begin
        if (state == IDLE && InValid) begin
            a_r <= PW'(A);
            b_r <= PW'(B);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            idx   <= '0;
            GE    <= 1'b0;
            EQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        idx   <= IW'(D - 1);
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (!eq_d) begin
                        GE    <= ge_d;
                        EQ    <= 1'b0;
                        state <= DONE;
                    end else if (idx == '0) begin
                        GE    <= 1'b1;
                        EQ    <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (OutReady)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
